// File: rtl/rca_share_pkg.sv
// Shared definitions for the shared ripple-carry adder arbiter.
package rca_share_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Tag width for n requesters, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Combinational ripple-carry adder/subtractor; the carry-out is dropped so results wrap.
module ripple_carry_adder #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic                 add_sub_b,
  output logic [BUS_WIDTH-1:0] out
);

  logic [BUS_WIDTH-1:0] b_eff;

  assign b_eff = in2 ^ {BUS_WIDTH{add_sub_b}};

  always_comb begin
    logic c;
    c   = add_sub_b;
    out = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      out[i] = in1[i] ^ b_eff[i] ^ c;
      c      = (in1[i] & b_eff[i]) | (c & (in1[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins, wrapping to 0.
module rr_arbiter
  import rca_share_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    hi_mask, req_hi, cand;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    req_hi = req & hi_mask;
    // Nothing at or above the pointer: fall back to the wrapped search from 0.
    cand   = (|req_hi) ? req_hi : req;

    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IdxW'(i);
      end
    end

    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rca_share_arbiter.sv
// Shares one ripple-carry adder among NUM_REQ requesters through a two-stage
// pipeline (operand stage A, result stage B) with a tagged valid/ready response.
module rca_share_arbiter
  import rca_share_pkg::*;
#(
  parameter  int unsigned BUS_WIDTH = 32,
  parameter  int unsigned NUM_REQ   = 4,
  localparam int unsigned ID_WIDTH  = clog2_min1(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_add_sub_b,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BUS_WIDTH-1:0]         rsp_out,
  output logic [ID_WIDTH-1:0]          rsp_id
);

  logic                 a_valid_q, a_op_q;
  logic [BUS_WIDTH-1:0] a_in1_q, a_in2_q;
  logic [ID_WIDTH-1:0]  a_id_q;
  logic                 b_valid_q;
  logic [BUS_WIDTH-1:0] b_out_q;
  logic [ID_WIDTH-1:0]  b_id_q;

  logic                 b_load, a_free, accept;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic [BUS_WIDTH-1:0] sel_in1, sel_in2, sum;
  logic                 sel_op;

  assign b_load = a_valid_q && (!b_valid_q || rsp_ready);
  assign a_free = !a_valid_q || b_load;

  // Gated by rst_n so no requester sees a handshake while reset is held.
  assign req_ready = (rst_n && a_free) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_in1 = req_in1[i*BUS_WIDTH +: BUS_WIDTH];
        sel_in2 = req_in2[i*BUS_WIDTH +: BUS_WIDTH];
        sel_op  = req_add_sub_b[i];
      end
    end
  end

  ripple_carry_adder #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_add (
    .in1      (a_in1_q),
    .in2      (a_in2_q),
    .add_sub_b(a_op_q == OP_SUB),
    .out      (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_op_q    <= OP_ADD;
      a_in1_q   <= '0;
      a_in2_q   <= '0;
      a_id_q    <= '0;
      b_valid_q <= 1'b0;
      b_out_q   <= '0;
      b_id_q    <= '0;
    end else begin
      if (a_free) begin
        a_valid_q <= accept;
        if (accept) begin
          a_in1_q <= sel_in1;
          a_in2_q <= sel_in2;
          a_op_q  <= sel_op;
          a_id_q  <= grant_idx;
        end
      end
      if (b_load) begin
        b_valid_q <= 1'b1;
        b_out_q   <= sum;
        b_id_q    <= a_id_q;
      end else if (rsp_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = b_valid_q;
  assign rsp_out   = b_out_q;
  assign rsp_id    = b_id_q;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Self-checking bench for rca_share_arbiter: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_rca_share_arbiter;
  import rca_share_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_add_sub_b = '0;
  logic [N*W-1:0] req_in1, req_in2;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_out;
  logic [IW-1:0]  rsp_id;

  logic [W-1:0] op1[N];
  logic [W-1:0] op2[N];

  int total = 0;
  int bad   = 0;
  int edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_in1[i*W +: W] = op1[i];
      req_in2[i*W +: W] = op2[i];
    end
  end

  rca_share_arbiter #(
    .BUS_WIDTH(W),
    .NUM_REQ  (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_add_sub_b(req_add_sub_b),
    .req_in1      (req_in1),
    .req_in2      (req_in2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_id       (rsp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op);
    logic [W-1:0] r;
    r = (op == OP_SUB) ? a - b : a + b;
    return r;
  endfunction

  // Reference model: in-flight operations in accept order, plus a rotating priority.
  typedef struct {
    int           id;
    logic [W-1:0] res;
    int           acc;
  } item_t;
  item_t q[$];
  int    ptr_m = 0;

  task automatic model_reset();
    q.delete();
    ptr_m = 0;
  endtask

  // Called mid-cycle with inputs settled; checks outputs then advances the model.
  task automatic model_cycle();
    logic         exp_v, free;
    logic [N-1:0] exp_rdy;
    int           g;
    item_t        it;
    exp_v = (q.size() > 0) && (edges >= q[0].acc + 1);
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      chk("rsp_out", rsp_out, q[0].res);
      chk("rsp_id", rsp_id, q[0].id);
    end
    free = (q.size() < 2) || rsp_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (g < 0 && req_valid[j]) g = j;
    end
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (exp_v && rsp_ready) void'(q.pop_front());
    if (exp_rdy != '0) begin
      it.id  = g;
      it.res = ref_op(op1[g], op2[g], req_add_sub_b[g]);
      it.acc = edges + 1;
      q.push_back(it);
      ptr_m = (g + 1) % N;
    end
  endtask

  // One clock: settle, model-check, clock, optionally drop requesters that were accepted.
  task automatic drive_cycle(input logic drop);
    logic [N-1:0] acc_mask;
    #1;
    acc_mask = req_valid & req_ready;
    model_cycle();
    @(posedge clk);
    #1;
    if (drop) req_valid = req_valid & ~acc_mask;
  endtask

  typedef struct {
    int           id;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[6];
  logic [N-1:0] sparse_exp[4];
  int           seq_n, n_acc;
  logic         held;
  logic [W-1:0] hold_out;
  logic [IW-1:0] hold_id;

  initial begin
    vecs[0] = '{id: 2, op: OP_ADD, a: 8'h12, b: 8'h34, exp: 8'h46};
    vecs[1] = '{id: 0, op: OP_SUB, a: 8'h03, b: 8'h05, exp: 8'hFE};
    vecs[2] = '{id: 0, op: OP_ADD, a: 8'hFF, b: 8'h02, exp: 8'h01};
    vecs[3] = '{id: 1, op: OP_SUB, a: 8'h80, b: 8'h01, exp: 8'h7F};
    vecs[4] = '{id: 3, op: OP_ADD, a: 8'h7F, b: 8'h01, exp: 8'h80};
    vecs[5] = '{id: 3, op: OP_SUB, a: 8'h00, b: 8'h00, exp: 8'h00};
    sparse_exp[0] = 4'b0010;
    sparse_exp[1] = 4'b1000;
    sparse_exp[2] = 4'b0010;
    sparse_exp[3] = 4'b1000;
    for (int i = 0; i < N; i++) begin
      op1[i] = '0;
      op2[i] = '0;
    end

    // Reset state, with requests pending to show req_ready stays low.
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_out", rsp_out, 0);
    chk("reset_rsp_id", rsp_id, 0);
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Table of single operations, each drained before the next.
    for (int v = 0; v < 6; v++) begin
      op1[vecs[v].id]           = vecs[v].a;
      op2[vecs[v].id]           = vecs[v].b;
      req_add_sub_b[vecs[v].id] = vecs[v].op;
      req_valid                 = '0;
      req_valid[vecs[v].id]     = 1'b1;
      #1;
      chk("vec_ready", req_ready, 32'(1) << vecs[v].id);
      drive_cycle(1'b1);
      drive_cycle(1'b1);
      #1;
      chk("vec_valid", rsp_valid, 1);
      chk("vec_out", rsp_out, vecs[v].exp);
      chk("vec_id", rsp_id, vecs[v].id);
      drive_cycle(1'b1);
      drive_cycle(1'b1);
    end

    // Fairness: everyone requesting, no backpressure.
    for (int i = 0; i < N; i++) begin
      op1[i] = W'(8'h10 * i + 1);
      op2[i] = W'(i);
      req_add_sub_b[i] = OP_ADD;
    end
    req_valid = '1;
    seq_n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rsp_valid) begin
        chk("rr_seq", rsp_id, seq_n % N);
        seq_n++;
      end
      #0;
      model_cycle();
      @(posedge clk);
      #1;
    end
    chk("rr_count", seq_n, 10);
    req_valid = '0;
    repeat (3) drive_cycle(1'b1);

    // Backpressure: three requesters, response held off for five cycles.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op1[i] = W'(8'hA0 + i);
      op2[i] = W'(8'h05 * (i + 1));
      req_add_sub_b[i] = logic'(i & 1);
    end
    req_valid = 4'b0111;
    n_acc = 0;
    held  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(req_valid & req_ready)) n_acc++;
      if (rsp_valid) begin
        if (!held) begin
          hold_out = rsp_out;
          hold_id  = rsp_id;
          held     = 1'b1;
        end else begin
          chk("bp_out_stable", rsp_out, hold_out);
          chk("bp_id_stable", rsp_id, hold_id);
        end
      end
      model_cycle();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(req_valid & req_ready);
    end
    #1;
    chk("bp_accepts", n_acc, 2);
    chk("bp_ready_zero", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (6) drive_cycle(1'b1);

    // Reset while both stages are full.
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    repeat (4) drive_cycle(1'b1);
    req_valid = 4'b1111;
    #2;
    chk("mid_full_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_id", rsp_id, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    model_cycle();
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) drive_cycle(1'b1);

    // Sparse requesters from a fresh pointer, then confirm the pointer wrapped to 0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sparse_grant", req_ready, sparse_exp[k]);
      model_cycle();
      @(posedge clk);
      #1;
    end
    req_valid = 4'b1001;
    #1;
    chk("wrap_grant", req_ready, 4'b0001);
    model_cycle();
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) drive_cycle(1'b1);

    // Randomized traffic; requesters hold operands until accepted.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] acc_mask;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          op1[i]           = W'($urandom);
          op2[i]           = W'($urandom);
          req_add_sub_b[i] = logic'($urandom_range(0, 1));
          req_valid[i]     = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_mask = req_valid & req_ready;
      model_cycle();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc_mask;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) drive_cycle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_share_arbiter.md
Name: rca_share_arbiter

Overview:
- Shares one `ripple_carry_adder` instance between NUM_REQ independent requesters.
- Each requester offers an add/subtract operation over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle; operands are registered, added, and the result is registered.
- The result is returned over a valid/ready response channel, tagged with the requester index.
- Sits between several datapath clients and the shared adder resource.

Parameters:
- BUS_WIDTH, 32, operand/result width; passed to `ripple_carry_adder`.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_WIDTH, derived localparam, max(1, clog2(NUM_REQ)); width of the requester tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_add_sub_b  in  NUM_REQ  per-requester op: 0 = in1+in2, 1 = in1-in2.
- req_in1  in  NUM_REQ*BUS_WIDTH  packed operand 1; requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_in2  in  NUM_REQ*BUS_WIDTH  packed operand 2; same packing as req_in1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_out  out  BUS_WIDTH  result, modulo 2^BUS_WIDTH.
- rsp_id  out  ID_WIDTH  index of the requester that produced the result.

Behaviour:
- Reset (async assert, sync release):
  - Stage A and stage B valids = 0; rsp_valid = 0.
  - rsp_out = 0, rsp_id = 0; operand registers = 0.
  - Round-robin pointer = 0.
  - req_ready = 0 while rst_n is low.
- Pipeline:
  - Stage A holds a_in1, a_in2, a_op, a_id, a_valid.
  - The adder is combinational from stage A.
  - Stage B holds the result, tag and valid, and drives rsp_*.
- Advance rules:
  - b_load = a_valid && (!b_valid || rsp_ready).
  - a_free = !a_valid || b_load.
- Arbitration:
  - grant = first i with req_valid[i] = 1, searching from pointer upward and wrapping at NUM_REQ-1 -> 0.
  - req_ready[i] = grant[i] && a_free. req_ready is combinational, may depend on req_valid and rsp_ready, and is low for non-granted requesters.
  - Accept (req_valid[i] && req_ready[i]): stage A captures requester i's operands, op and id on the edge; pointer <= (i+1) mod NUM_REQ.
  - No accept: pointer is unchanged.
- Latency and throughput:
  - Accept at edge N -> rsp_valid high after edge N+1, with no backpressure.
  - Sustained throughput is 1 result/cycle.
- Arithmetic:
  - Subtract is two's complement (in2 inverted, carry-in 1).
  - Carry/borrow-out is discarded; the result wraps modulo 2^BUS_WIDTH.
  - No overflow flag.
- Backpressure:
  - While rsp_valid && !rsp_ready: rsp_out and rsp_id are held stable.
  - Stage A may fill and hold; once both stages are full, all req_ready = 0.
  - Holding rsp_ready low stalls without any loss or duplication of operations.
- Simultaneous events:
  - A stage B drain and a stage A refill in the same cycle is legal (full throughput).
  - A new accept in the same cycle that stage A moves to B is legal.
- Requester obligations: a requester must hold valid and operands stable until accepted. The block does not check this.
- Reset mid-operation: in-flight operations are dropped, rsp_valid = 0 immediately, and the pointer returns to 0.

Decomposition:
- Package `rca_share_pkg`:
  - Function clog2_min1 (used to derive ID_WIDTH).
  - Localparams OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module `rr_arbiter`:
  - Parameter N; inputs clk, rst_n, req[N-1:0], advance.
  - Outputs grant[N-1:0] (one-hot or zero) and grant_idx.
  - Pointer update happens only when advance is high.
- Existing `ripple_carry_adder` is instantiated unchanged, with BUS_WIDTH passed through.

Test Plan (BUS_WIDTH=8, NUM_REQ=4):
- Single add: req 2 presents 0x12+0x34 with rsp_ready=1 -> req_ready[2] is high that cycle; one cycle later rsp_valid=1, rsp_out=0x46, rsp_id=2.
- Sub/wrap:
  - req 0 presents 0x03-0x05 -> rsp_out=0xFE.
  - Then 0xFF+0x02 -> rsp_out=0x01.
  - No extra outputs are produced.
- Round-robin fairness: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1...; one result per cycle after the first.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles with 3 requesters active -> exactly 2 accepts, then all req_ready=0.
  - rsp_out/rsp_id stable throughout.
  - On release, results drain in accept order with none lost or duplicated.
- Sparse/wrap pointer:
  - Only req 3 and req 1 valid, pointer at 0 -> grants alternate 1,3,1,3.
  - After req 3 is granted, the pointer wraps to 0.
- Reset mid-flight: assert rst_n=0 asynchronously while both stages are full -> rsp_valid drops before the next clock edge; after release, req 0 is granted first.
